// File: rtl/door_timer.sv
// rtl/door_timer.sv - tick-driven elevator door sequencer
// Phases are measured in prescaler ticks; a closing door reverses by the distance it has travelled.
module door_timer #(
  parameter int OPEN_TICKS = 5,
  parameter int MOVE_TICKS = 3,
  parameter int WIDTH      = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             tick,
  input  logic             stopped,
  input  logic             open_req,
  input  logic             obstruct,
  output logic             motor_open,
  output logic             motor_close,
  output logic             door_closed,
  output logic             door_open,
  output logic [WIDTH-1:0] ticks_left
);

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] OPEN_LOAD = WIDTH'(OPEN_TICKS);
  localparam logic [WIDTH-1:0] MOVE_LOAD = WIDTH'(MOVE_TICKS);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] timer, timer_n;
  logic             req;
  logic             phase_end;
  logic             dec;
  logic [WIDTH-1:0] elapsed;

  assign req       = open_req | obstruct;
  assign phase_end = tick && (timer == ONE);
  // Never decrement below 1: the phase ends at 1 instead of wrapping.
  assign dec       = tick && (timer > ONE);
  assign elapsed   = MOVE_LOAD - timer;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= CLOSED;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    unique case (state)
      CLOSED: begin
        timer_n = '0;
        if (stopped && req) begin
          state_n = OPENING;
          timer_n = MOVE_LOAD;
        end
      end
      OPENING: begin
        if (phase_end) begin
          state_n = OPEN;
          timer_n = OPEN_LOAD;
        end else if (dec) begin
          timer_n = timer - ONE;
        end
      end
      OPEN: begin
        if (req) begin
          timer_n = OPEN_LOAD;
        end else if (phase_end) begin
          state_n = CLOSING;
          timer_n = MOVE_LOAD;
        end else if (dec) begin
          timer_n = timer - ONE;
        end
      end
      CLOSING: begin
        // Reversal reopens by exactly the distance already closed.
        if (req) begin
          if (elapsed != '0) begin
            state_n = OPENING;
            timer_n = elapsed;
          end else begin
            state_n = OPEN;
            timer_n = OPEN_LOAD;
          end
        end else if (phase_end) begin
          state_n = CLOSED;
          timer_n = '0;
        end else if (dec) begin
          timer_n = timer - ONE;
        end
      end
      default: begin
        state_n = CLOSED;
        timer_n = '0;
      end
    endcase
  end

  assign door_closed = (state == CLOSED);
  assign motor_open  = (state == OPENING);
  assign door_open   = (state == OPEN);
  assign motor_close = (state == CLOSING);
  assign ticks_left  = timer;

endmodule

// File: doc/door_timer.md
# door_timer

Tick-driven door sequencer for the elevator car. It consumes the periodic one-cycle tick from the prescaler counter and runs the door through closed, opening, open-dwell and closing phases, measuring each phase in ticks. It sits between the car motion controller, which supplies `stopped` and `open_req`, and the door motor drivers. Obstruction and re-open requests hold the door open or reverse a closing door.

## Interface
- `OPEN_TICKS`, default 5: dwell time in ticks with the door fully open; must be ≥1.
- `MOVE_TICKS`, default 3: travel time in ticks for a full open or close; must be ≥1.
- `WIDTH`, default 4: timer width; must hold max(OPEN_TICKS, MOVE_TICKS).
- `clk`  in  1  system clock, rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  one-cycle time-base strobe from the prescaler.
- `stopped`  in  1  car is stationary at a floor; level.
- `open_req`  in  1  request to open or hold the door; level, sampled every cycle.
- `obstruct`  in  1  door-edge sensor; level.
- `motor_open`  out  1  drive door toward open.
- `motor_close`  out  1  drive door toward closed.
- `door_closed`  out  1  door fully closed; the car may move.
- `door_open`  out  1  door fully open.
- `ticks_left`  out  WIDTH  current timer value.

## Operation
- State register: CLOSED, OPENING, OPEN, CLOSING. Timer register is WIDTH bits.
- All outputs are Moore-decoded from registers, so there is no combinational path from inputs to outputs.
  - `door_closed` = CLOSED
  - `motor_open` = OPENING
  - `door_open` = OPEN
  - `motor_close` = CLOSING
  - `ticks_left` = timer
- Exactly one of the four state flags is high at all times.
- Phase timing rule: a phase ends on a cycle with `tick`=1 and timer==1. Otherwise, `tick`=1 decrements the timer and `tick`=0 holds it. A phase loaded with N therefore lasts exactly N ticks.
- CLOSED:
  - Timer is held at 0.
  - If `stopped`=1 and (`open_req`=1 or `obstruct`=1), go to OPENING and load MOVE_TICKS.
  - Requests while `stopped`=0 are ignored and are not remembered.
- OPENING:
  - Inputs are ignored.
  - At phase end, go to OPEN and load OPEN_TICKS.
- OPEN:
  - If `open_req`=1 or `obstruct`=1, reload OPEN_TICKS. Reload has priority over a simultaneous tick or phase end.
  - At phase end with no reload, go to CLOSING and load MOVE_TICKS.
- CLOSING:
  - If `open_req`=1 or `obstruct`=1, reverse. Let elapsed = MOVE_TICKS − timer.
    - elapsed ≥1: go to OPENING and load elapsed.
    - elapsed ==0 (no tick consumed yet): go to OPEN and load OPEN_TICKS.
  - Reversal has priority over a simultaneous tick or phase end.
  - At phase end with no reversal, go to CLOSED and load 0.
- `stopped` falling outside CLOSED has no effect. The door always completes its sequence.
- Timer arithmetic is unsigned WIDTH bits. The timer never wraps: decrement happens only when timer ≥2, and phase end occurs at 1.

## Timing
- Reset (`nrst`=0) takes effect immediately and asynchronously:
  - state CLOSED, timer 0
  - `door_closed`=1
  - `motor_open`=`motor_close`=`door_open`=0
  - `ticks_left`=0
- Reset asserted mid-sequence aborts to CLOSED with no further motor drive.
- First transition is possible on the first rising edge after `nrst` deasserts.
- Latency: an input condition sampled at edge k changes the outputs just after edge k (one registered stage).
- With `tick` held high:
  - open → fully open: MOVE_TICKS cycles
  - dwell: OPEN_TICKS cycles
  - close: MOVE_TICKS cycles

## Test plan
- **Basic cycle**
  - Stimulus: reset, `tick`=1 every cycle, `stopped`=1, `open_req` pulsed for 1 cycle.
  - Required response: OPENING 3 cycles, OPEN 5 cycles, CLOSING 3 cycles, then CLOSED. `ticks_left` sequences 3,2,1 / 5,4,3,2,1 / 3,2,1.
- **Sparse ticks**
  - Stimulus: `tick` high one cycle in 4, same request.
  - Required response: OPENING lasts 12 cycles and OPEN lasts 20 cycles. Timer changes only on tick cycles.
- **Hold**
  - Stimulus: `obstruct` held high for 10 cycles starting in OPEN with timer=2.
  - Required response: timer reads 5 throughout. After release the door dwells 5 more ticks, then closes.
- **Reversal**
  - Stimulus: `open_req` in CLOSING with timer=1 (2 ticks elapsed).
  - Required response: OPENING is loaded with 2, lasts 2 ticks, then OPEN is loaded with 5.
  - Edge case: `open_req` on the first CLOSING cycle with no tick yet gives OPEN directly with timer=5.
- **Ignored request and priority**
  - Stimulus 1: `open_req`=1 while `stopped`=0.
  - Required response: stays CLOSED, and the request is not latched after `stopped` rises with `open_req`=0.
  - Stimulus 2: `tick` and `obstruct` arrive together at OPEN timer=1.
  - Required response: reload to 5, with no entry into CLOSING.
- **Async reset**
  - Stimulus: `nrst` pulsed low mid-OPENING, between clock edges.
  - Required response: outputs return to reset values immediately. Checks hold every cycle: one-hot state flags, and `motor_open`·`motor_close`=0.
